// File: rtl/csr_access_unit.sv
// csr_access_unit: initiator side of the CSR access interface.
// Executes one Zicsr instruction at a time (CSRRW/RS/RC and the immediate
// forms). It issues read and write requests to the CSR file, computes the
// read-modify-write value and returns either an rd writeback or an
// illegal-instruction exception.
//
// Handshakes:
//   instr:   an instruction transfers on a cycle where instr_valid && instr_ready
//            are both high; instr_ready is high only in IDLE.
//   csr_req: csr_req_valid is raised in a *_REQ state and holds write/addr/wdata
//            stable until a cycle with csr_req_ready high; that cycle is the
//            transfer.
//   csr_rsp: valid-only. csr_rsp_valid is honoured only in a *_WAIT state (the
//            earliest is the cycle after the transfer) and ignored elsewhere.
module csr_access_unit #(
   parameter int XLEN        = 32,
   parameter int RSP_TIMEOUT = 16
) (
   input  logic            clock,
   input  logic            reset,
   // instruction side
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [2:0]      instr_funct3,
   input  logic [11:0]     instr_csr_addr,
   input  logic [4:0]      instr_rs1_idx,
   input  logic [4:0]      instr_rd_idx,
   input  logic [XLEN-1:0] instr_rs1_value,
   input  logic [1:0]      priv_mode,
   // CSR file request
   output logic            csr_req_valid,
   input  logic            csr_req_ready,
   output logic            csr_req_write,
   output logic [11:0]     csr_req_addr,
   output logic [XLEN-1:0] csr_req_wdata,
   // CSR file response
   input  logic            csr_rsp_valid,
   input  logic [XLEN-1:0] csr_rsp_rdata,
   input  logic            csr_rsp_illegal,
   // completion
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            done_valid,
   output logic            illegal_instr_exception,
   // FSM state, for observation only
   output logic [2:0]      dbg_state
);

   localparam int CNT_W = $clog2(RSP_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WR_REQ  = 3'd3,
      S_WR_WAIT = 3'd4,
      S_DONE    = 3'd5
   } state_e;

   // Operation encoding is funct3[1:0]: 01=RW, 10=RS, 11=RC, 00=illegal.
   localparam logic [1:0] OP_RW = 2'b01;
   localparam logic [1:0] OP_RS = 2'b10;
   localparam logic [1:0] OP_RC = 2'b11;

   state_e            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [XLEN-1:0]   src_q, src_d;
   logic [11:0]       addr_q, addr_d;
   logic [4:0]        rd_q, rd_d;
   logic              do_read_q, do_read_d;
   logic              do_write_q, do_write_d;
   logic [XLEN-1:0]   old_q, old_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              exc_q, exc_d;

   // Decode of the offered instruction, used only at acceptance.
   logic [1:0]        acc_op;
   logic [XLEN-1:0]   acc_src;
   logic              acc_is_rw;
   logic              acc_do_read;
   logic              acc_do_write;
   logic              acc_illegal;

   // Write value built from the captured old value, never from a re-read.
   logic [XLEN-1:0]   wdata;

   // Decode the offered instruction and run the pre-checks.
   always_comb begin
      acc_op       = instr_funct3[1:0];
      acc_src      = instr_funct3[2] ? {{(XLEN-5){1'b0}}, instr_rs1_idx} : instr_rs1_value;
      acc_is_rw    = (acc_op == OP_RW);
      acc_do_read  = !(acc_is_rw && (instr_rd_idx == 5'd0));
      acc_do_write = acc_is_rw || (instr_rs1_idx != 5'd0);
      acc_illegal  = (acc_op == 2'b00)
                   || (instr_csr_addr[9:8] > priv_mode)
                   || (acc_do_write && (instr_csr_addr[11:10] == 2'b11));
   end

   // Read-modify-write value for the write request.
   always_comb begin
      case (op_q)
         OP_RS:   wdata = old_q | src_q;
         OP_RC:   wdata = old_q & ~src_q;
         default: wdata = src_q;
      endcase
   end

   // Next-state logic: sequencing, capture of old value, timeout counting.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      src_d      = src_q;
      addr_d     = addr_q;
      rd_d       = rd_q;
      do_read_d  = do_read_q;
      do_write_d = do_write_q;
      old_d      = old_q;
      cnt_d      = cnt_q;
      exc_d      = exc_q;

      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               op_d       = acc_op;
               src_d      = acc_src;
               addr_d     = instr_csr_addr;
               rd_d       = instr_rd_idx;
               do_read_d  = acc_do_read;
               do_write_d = acc_do_write;
               old_d      = '0;
               cnt_d      = '0;
               exc_d      = acc_illegal;
               if (acc_illegal) begin
                  state_d = S_DONE;
               end else if (acc_do_read) begin
                  state_d = S_RD_REQ;
               end else begin
                  state_d = S_WR_REQ;
               end
            end
         end

         S_RD_REQ: begin
            if (csr_req_ready) begin
               cnt_d   = '0;
               state_d = S_RD_WAIT;
            end
         end

         S_RD_WAIT: begin
            if (csr_rsp_valid) begin
               if (csr_rsp_illegal) begin
                  exc_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  old_d   = csr_rsp_rdata;
                  state_d = do_write_q ? S_WR_REQ : S_DONE;
               end
            end else if (cnt_q == CNT_LAST) begin
               exc_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_WR_REQ: begin
            if (csr_req_ready) begin
               cnt_d   = '0;
               state_d = S_WR_WAIT;
            end
         end

         S_WR_WAIT: begin
            if (csr_rsp_valid) begin
               exc_d   = csr_rsp_illegal;
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               exc_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from the registered state; data outputs are zero unless
   // their qualifying strobe is high.
   always_comb begin
      instr_ready             = 1'b0;
      csr_req_valid           = 1'b0;
      csr_req_write           = 1'b0;
      csr_req_addr            = '0;
      csr_req_wdata           = '0;
      wb_valid                = 1'b0;
      wb_rd                   = '0;
      wb_data                 = '0;
      done_valid              = 1'b0;
      illegal_instr_exception = 1'b0;
      dbg_state               = state_q;

      case (state_q)
         S_IDLE: begin
            instr_ready = 1'b1;
         end
         S_RD_REQ: begin
            csr_req_valid = 1'b1;
            csr_req_addr  = addr_q;
         end
         S_WR_REQ: begin
            csr_req_valid = 1'b1;
            csr_req_write = 1'b1;
            csr_req_addr  = addr_q;
            csr_req_wdata = wdata;
         end
         S_DONE: begin
            done_valid              = 1'b1;
            illegal_instr_exception = exc_q;
            if (!exc_q && do_read_q && (rd_q != 5'd0)) begin
               wb_valid = 1'b1;
               wb_rd    = rd_q;
               wb_data  = old_q;
            end
         end
         default: begin
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         src_q      <= '0;
         addr_q     <= '0;
         rd_q       <= '0;
         do_read_q  <= 1'b0;
         do_write_q <= 1'b0;
         old_q      <= '0;
         cnt_q      <= '0;
         exc_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         src_q      <= src_d;
         addr_q     <= addr_d;
         rd_q       <= rd_d;
         do_read_q  <= do_read_d;
         do_write_q <= do_write_d;
         old_q      <= old_d;
         cnt_q      <= cnt_d;
         exc_q      <= exc_d;
      end
   end

endmodule
